// File: rtl/sd_card_cmd_responder_if.sv
// rtl/sd_card_cmd_responder_if.sv - CMD line and card-logic signal bundle for the SD command responder
interface sd_card_cmd_responder_if;
  logic        iCmd_in;
  logic        oCmd_out;
  logic        oCmd_oe;
  logic [37:0] oCommand;
  logic        oCommand_valid;
  logic [37:0] iResponse;
  logic        iResponse_valid;
  logic        iNo_response;
  logic        oBusy;
  logic        oCrc_error;
  logic        oFrame_error;
  logic        oTimeout;
  logic        oTransmission_complete;

  modport slave (
    input  iCmd_in, iResponse, iResponse_valid, iNo_response,
    output oCmd_out, oCmd_oe, oCommand, oCommand_valid, oBusy,
           oCrc_error, oFrame_error, oTimeout, oTransmission_complete
  );

  modport master (
    output iCmd_in, iResponse, iResponse_valid, iNo_response,
    input  oCmd_out, oCmd_oe, oCommand, oCommand_valid, oBusy,
           oCrc_error, oFrame_error, oTimeout, oTransmission_complete
  );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - card-side SD CMD line endpoint: receive/check host command, send response
module sd_card_cmd_responder #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic                     iClock_SD,
  input  logic                     iReset,
  sd_card_cmd_responder_if.slave   bus
);
  localparam int NCR_W = $clog2(NCR_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_RECEIVE, S_CHECK, S_WAIT_RESP, S_SEND} state_e;

  state_e             state_q, state_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [47:0]        shift_q, shift_d;
  logic [6:0]         crc_q, crc_d;
  logic [NCR_W-1:0]   ncr_q, ncr_d;
  logic [37:0]        command_q, command_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               crc_err_q, crc_err_d;
  logic               frame_err_q, frame_err_d;
  logic               timeout_q, timeout_d;
  logic               tx_done_q, tx_done_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_word(input logic [39:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  always_ff @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      crc_q       <= '0;
      ncr_q       <= '0;
      command_q   <= '0;
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      ncr_q       <= ncr_d;
      command_q   <= command_d;
      cmd_valid_q <= cmd_valid_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      tx_done_q   <= tx_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    ncr_d       = ncr_q;
    command_d   = command_q;
    cmd_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    tx_done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.iCmd_in) begin
          state_d   = S_RECEIVE;
          bit_cnt_d = 6'd1;
          shift_d   = '0;
          crc_d     = crc7_step(7'h00, 1'b0);
        end
      end
      S_RECEIVE: begin
        // bit_cnt_q is the number of bits already taken; the CRC covers the first 40
        shift_d   = {shift_q[46:0], bus.iCmd_in};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q < 6'd40) crc_d = crc7_step(crc_q, bus.iCmd_in);
        if (bit_cnt_q == 6'd47) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (!shift_q[46] || !shift_q[0]) begin
          frame_err_d = 1'b1;
        end else if (shift_q[7:1] != crc_q) begin
          crc_err_d = 1'b1;
        end else begin
          command_d   = shift_q[45:8];
          cmd_valid_d = 1'b1;
          ncr_d       = NCR_W'(1);
          state_d     = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (bus.iNo_response) begin
          state_d = S_IDLE;
        end else if (ncr_q >= NCR_W'(NCR_MIN) && bus.iResponse_valid) begin
          shift_d   = {2'b00, bus.iResponse, crc7_word({2'b00, bus.iResponse}), 1'b1};
          bit_cnt_d = '0;
          state_d   = S_SEND;
        end else if (ncr_q == NCR_W'(NCR_MAX)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          ncr_d = ncr_q + NCR_W'(1);
        end
      end
      S_SEND: begin
        shift_d   = {shift_q[46:0], 1'b1};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd47) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Driving straight from state_q lets an asynchronous reset release the line at once
  assign bus.oCmd_oe                = (state_q == S_SEND);
  assign bus.oCmd_out               = (state_q == S_SEND) ? shift_q[47] : 1'b1;
  assign bus.oCommand               = command_q;
  assign bus.oCommand_valid         = cmd_valid_q;
  assign bus.oBusy                  = (state_q != S_IDLE);
  assign bus.oCrc_error             = crc_err_q;
  assign bus.oFrame_error           = frame_err_q;
  assign bus.oTimeout               = timeout_q;
  assign bus.oTransmission_complete = tx_done_q;
endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb/tb_sd_card_cmd_responder.sv - bench for sd_card_cmd_responder with a CMD-line reference model
module tb_sd_card_cmd_responder;
  localparam int NCR_MIN = 2;
  localparam int NCR_MAX = 64;

  logic clk;
  logic rst_n;
  sd_card_cmd_responder_if bus();

  sd_card_cmd_responder #(.NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
    .iClock_SD (clk),
    .iReset    (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  int cyc = 0;
  int n_valid, n_crc, n_frame, n_to, n_tc;
  int valid_cyc, to_cyc, tc_cyc, first_oe_cyc;
  logic line_q[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.oCommand_valid) begin n_valid++; valid_cyc = cyc; end
    if (bus.oCrc_error) n_crc++;
    if (bus.oFrame_error) n_frame++;
    if (bus.oTimeout) begin n_to++; to_cyc = cyc; end
    if (bus.oTransmission_complete) begin n_tc++; tc_cyc = cyc; end
    if (bus.oCmd_oe) begin
      if (first_oe_cyc < 0) first_oe_cyc = cyc;
      line_q.push_back(bus.oCmd_out);
    end
  end

  // CRC7 as the remainder of polynomial long division by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] ref_resp_frame(input logic [37:0] r);
    return {2'b00, r, ref_crc7({2'b00, r}), 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    n_valid = 0; n_crc = 0; n_frame = 0; n_to = 0; n_tc = 0;
    valid_cyc = -1000; to_cyc = -1000; tc_cyc = -1000; first_oe_cyc = -1;
    line_q.delete();
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      bus.iCmd_in = f[i];
    end
    @(negedge clk);
    bus.iCmd_in = 1'b1;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.oCommand_valid) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [47:0] line_word();
    logic [47:0] w;
    w = '0;
    foreach (line_q[i]) w = {w[46:0], line_q[i]};
    return w;
  endfunction

  task automatic run_no_response(input logic [47:0] frame);
    logic ok;
    clear_mon();
    send_frame(frame);
    wait_valid(ok);
    bus.iNo_response = 1'b1;
    @(negedge clk);
    bus.iNo_response = 1'b0;
    repeat (5) @(negedge clk);
    chk("noresp_valid_seen", ok, 1);
    chk("noresp_command", bus.oCommand, frame[45:8]);
    chk("noresp_valid_count", n_valid, 1);
    chk("noresp_no_drive", line_q.size(), 0);
    chk("noresp_idle", bus.oBusy, 0);
  endtask

  task automatic run_response(input logic [47:0] frame, input logic [37:0] resp,
                              input int d, input logic [47:0] exp_line);
    logic ok;
    int   lat;
    clear_mon();
    send_frame(frame);
    wait_valid(ok);
    chk("resp_valid_seen", ok, 1);
    chk("resp_command", bus.oCommand, frame[45:8]);
    if (d > 1) repeat (d - 1) @(negedge clk);
    bus.iResponse       = resp;
    bus.iResponse_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.oCmd_oe) break;
    end
    bus.iResponse_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.oTransmission_complete) break;
    end
    @(negedge clk);
    lat = (d < NCR_MIN) ? NCR_MIN : d;
    chk("start_latency", first_oe_cyc - valid_cyc, lat);
    chk("resp_len", line_q.size(), 48);
    chk("resp_line", line_word(), exp_line);
    chk("tc_latency", tc_cyc - first_oe_cyc, 48);
    chk("tc_count", n_tc, 1);
    chk("resp_no_err", n_crc + n_frame + n_to, 0);
    chk("resp_line_released", {bus.oCmd_oe, bus.oCmd_out}, 2'b01);
  endtask

  task automatic run_bad(input logic [47:0] frame, input logic [37:0] prev,
                         input int exp_frame, input int exp_crc);
    clear_mon();
    send_frame(frame);
    repeat (10) @(negedge clk);
    chk("bad_frame_err", n_frame, exp_frame);
    chk("bad_crc_err", n_crc, exp_crc);
    chk("bad_no_valid", n_valid, 0);
    chk("bad_command_kept", bus.oCommand, prev);
    chk("bad_no_drive", line_q.size(), 0);
  endtask

  initial begin
    logic        ok;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [37:0] resp;
    int          d;

    rst_n = 1'b0;
    bus.iCmd_in = 1'b1;
    bus.iResponse = '0;
    bus.iResponse_valid = 1'b0;
    bus.iNo_response = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe", bus.oCmd_oe, 0);
    chk("rst_out", bus.oCmd_out, 1);
    chk("rst_command", bus.oCommand, 0);
    chk("rst_busy", bus.oBusy, 0);
    chk("rst_pulses", {bus.oCommand_valid, bus.oCrc_error, bus.oFrame_error,
                       bus.oTimeout, bus.oTransmission_complete}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_no_response(48'h400000000095);
    run_response(48'h48000001AA87, 38'h08000001AA, 5, 48'h08000001AA13);
    run_response(48'h48000001AA87, 38'h08000001AA, 1, 48'h08000001AA13);

    run_bad(48'h48000001AA89, 38'h08000001AA, 0, 1);
    run_bad(48'h48000001AA86, 38'h08000001AA, 1, 0);
    run_bad(48'h08000001AA87, 38'h08000001AA, 1, 0);

    clear_mon();
    send_frame(48'h48000001AA87);
    wait_valid(ok);
    repeat (NCR_MAX + 6) @(negedge clk);
    chk("to_valid_seen", ok, 1);
    chk("to_count", n_to, 1);
    chk("to_latency", to_cyc - valid_cyc, NCR_MAX);
    chk("to_no_drive", line_q.size(), 0);
    chk("to_idle", bus.oBusy, 0);

    for (int k = 0; k < 4; k++) begin
      idx  = 6'($urandom_range(0, 63));
      arg  = $urandom;
      resp = {6'($urandom_range(0, 63)), 32'($urandom)};
      d    = $urandom_range(1, 9);
      run_response(ref_cmd_frame(idx, arg), resp, d, ref_resp_frame(resp));
    end

    clear_mon();
    send_frame(48'h48000001AA87);
    wait_valid(ok);
    bus.iResponse = 38'h08000001AA;
    bus.iResponse_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.oCmd_oe) break;
    end
    bus.iResponse_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_resp_driving", bus.oCmd_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", bus.oCmd_oe, 0);
    chk("async_rst_out", bus.oCmd_out, 1);
    chk("async_rst_busy", bus.oBusy, 0);
    chk("async_rst_command", bus.oCommand, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_pulses", n_tc + n_crc + n_frame + n_to, 0);
    run_no_response(48'h400000000095);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end
endmodule
